// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe FIM types: function numbering widths and the FLR request payload.
package ofs_fim_pcie_pkg;

  localparam int unsigned NUM_PF   = 8;
  localparam int unsigned PF_NUM_W = 3;
  localparam int unsigned VF_NUM_W = 11;

  typedef struct packed {
    logic                vf;
    logic [PF_NUM_W-1:0] pf_num;
    logic [VF_NUM_W-1:0] vf_num;
  } flr_req_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [PF_NUM_W-1:0] lowest_pf(input logic [NUM_PF-1:0] vec);
    lowest_pf = '0;
    for (int i = NUM_PF - 1; i >= 0; i--) begin
      if (vec[i]) lowest_pf = PF_NUM_W'(i);
    end
  endfunction

endpackage

// File: rtl/pcie_flr_vf_fifo.sv
// Small synchronous FIFO of pending VF FLR requests.
module pcie_flr_vf_fifo
  import ofs_fim_pcie_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  flr_req_t         i_data,
  input  logic             i_pop,
  output flr_req_t         o_data_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  flr_req_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count_c = r_count;
  assign o_data_c  = r_mem[r_rd_ptr];

  // A push into a full queue still lands when a pop frees the slot this cycle.
  assign w_wr = i_push && (!o_full_c || i_pop);
  assign w_rd = i_pop && !o_empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pcie_flr_resp.sv
// Device-side FLR responder: serialises PF/VF FLRs into one function reset at a time.
module pcie_flr_resp
  import ofs_fim_pcie_pkg::*;
#(
  parameter int unsigned VF_FIFO_DEPTH   = 4,
  parameter int unsigned RST_HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PF-1:0]   i_flr_pf_active,
  input  logic                i_flr_rcvd_vf,
  input  logic [PF_NUM_W-1:0] i_flr_rcvd_pf_num,
  input  logic [VF_NUM_W-1:0] i_flr_rcvd_vf_num,
  output logic [NUM_PF-1:0]   o_flr_pf_done,
  output logic                o_flr_completed_vf,
  output logic [PF_NUM_W-1:0] o_flr_completed_pf_num,
  output logic [VF_NUM_W-1:0] o_flr_completed_vf_num,
  output logic                o_func_rst_req,
  output logic                o_func_rst_vf,
  output logic [PF_NUM_W-1:0] o_func_rst_pf_num,
  output logic [VF_NUM_W-1:0] o_func_rst_vf_num,
  input  logic                i_func_rst_ack,
  output logic                o_vf_fifo_full,
  output logic                o_vf_drop
);

  localparam int unsigned CNT_W  = $clog2(VF_FIFO_DEPTH) + 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_ACK, S_DONE} state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [NUM_PF-1:0]   r_pf_act;
  logic [NUM_PF-1:0]   r_pf_act_d;
  logic [NUM_PF-1:0]   r_pf_pending;
  logic                r_vf_avail;
  flr_req_t            r_tgt;
  logic                r_req;
  logic [NUM_PF-1:0]   r_pf_done;
  logic                r_cmp_vf;
  logic                r_vf_full;
  logic                r_vf_drop;

  flr_req_t            w_push_data;
  flr_req_t            w_head;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [NUM_PF-1:0]   w_pf_rise;
  logic [PF_NUM_W-1:0] w_pf_sel;
  logic                w_start_pf;
  logic                w_pop;
  logic [NUM_PF-1:0]   w_pf_clr;
  logic                w_drop;

  assign w_push_data = '{vf: 1'b1, pf_num: i_flr_rcvd_pf_num, vf_num: i_flr_rcvd_vf_num};

  pcie_flr_vf_fifo #(.DEPTH(VF_FIFO_DEPTH)) u_vf_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (i_flr_rcvd_vf),
    .i_data    (w_push_data),
    .i_pop     (w_pop),
    .o_data_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count_c (w_count)
  );

  // PF requests always win arbitration over queued VF requests.
  assign w_pf_rise  = r_pf_act & ~r_pf_act_d;
  assign w_pf_sel   = lowest_pf(r_pf_pending);
  assign w_start_pf = (r_state == S_IDLE) && (|r_pf_pending);
  assign w_pop      = (r_state == S_IDLE) && !(|r_pf_pending) && r_vf_avail && !w_empty;
  assign w_pf_clr   = w_start_pf ? (NUM_PF'(1) << w_pf_sel) : '0;
  assign w_drop     = i_flr_rcvd_vf && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_pf_act     <= '0;
      r_pf_act_d   <= '0;
      r_pf_pending <= '0;
      r_vf_avail   <= 1'b0;
      r_tgt        <= '0;
      r_req        <= 1'b0;
      r_pf_done    <= '0;
      r_cmp_vf     <= 1'b0;
      r_vf_full    <= 1'b0;
      r_vf_drop    <= 1'b0;
    end else begin
      r_pf_act     <= i_flr_pf_active;
      r_pf_act_d   <= r_pf_act;
      // A fresh rising edge during service re-arms the PF for another pass.
      r_pf_pending <= (r_pf_pending & ~w_pf_clr) | w_pf_rise;
      r_vf_avail   <= !w_empty;
      r_vf_full    <= (w_count == CNT_W'(VF_FIFO_DEPTH));
      r_vf_drop    <= w_drop;

      case (r_state)
        S_IDLE: begin
          if (w_start_pf || w_pop) begin
            r_tgt      <= w_start_pf ? '{vf: 1'b0, pf_num: w_pf_sel, vf_num: '0} : w_head;
            r_state    <= S_ASSERT;
            r_req      <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        S_ASSERT: begin
          if (r_hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) r_state <= S_WAIT_ACK;
          else r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
        S_WAIT_ACK: begin
          if (i_func_rst_ack) begin
            r_state    <= S_DONE;
            r_req      <= 1'b0;
            r_hold_cnt <= '0;
            if (r_tgt.vf) r_cmp_vf <= 1'b1;
            else r_pf_done <= NUM_PF'(1) << r_tgt.pf_num;
          end
        end
        S_DONE: begin
          // Pulse for the first cycle, then one quiet cycle before arbitration.
          r_pf_done <= '0;
          r_cmp_vf  <= 1'b0;
          if (r_hold_cnt == '0) r_hold_cnt <= HOLD_W'(1);
          else r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_func_rst_req         = r_req;
  assign o_func_rst_vf          = r_tgt.vf;
  assign o_func_rst_pf_num      = r_tgt.pf_num;
  assign o_func_rst_vf_num      = r_tgt.vf_num;
  assign o_flr_pf_done          = r_pf_done;
  assign o_flr_completed_vf     = r_cmp_vf;
  assign o_flr_completed_pf_num = r_tgt.pf_num;
  assign o_flr_completed_vf_num = r_tgt.vf_num;
  assign o_vf_fifo_full         = r_vf_full;
  assign o_vf_drop              = r_vf_drop;

endmodule

// File: tb/tb_pcie_flr_resp.sv
// Directed bench for pcie_flr_resp with hand-computed expectations.
module tb_pcie_flr_resp;

  localparam int unsigned H = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_flr_pf_active;
  logic        i_flr_rcvd_vf;
  logic [2:0]  i_flr_rcvd_pf_num;
  logic [10:0] i_flr_rcvd_vf_num;
  logic [7:0]  o_flr_pf_done;
  logic        o_flr_completed_vf;
  logic [2:0]  o_flr_completed_pf_num;
  logic [10:0] o_flr_completed_vf_num;
  logic        o_func_rst_req;
  logic        o_func_rst_vf;
  logic [2:0]  o_func_rst_pf_num;
  logic [10:0] o_func_rst_vf_num;
  logic        i_func_rst_ack;
  logic        o_vf_fifo_full;
  logic        o_vf_drop;

  pcie_flr_resp #(.VF_FIFO_DEPTH(4), .RST_HOLD_CYCLES(H)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_flr_pf_active        (i_flr_pf_active),
    .i_flr_rcvd_vf          (i_flr_rcvd_vf),
    .i_flr_rcvd_pf_num      (i_flr_rcvd_pf_num),
    .i_flr_rcvd_vf_num      (i_flr_rcvd_vf_num),
    .o_flr_pf_done          (o_flr_pf_done),
    .o_flr_completed_vf     (o_flr_completed_vf),
    .o_flr_completed_pf_num (o_flr_completed_pf_num),
    .o_flr_completed_vf_num (o_flr_completed_vf_num),
    .o_func_rst_req         (o_func_rst_req),
    .o_func_rst_vf          (o_func_rst_vf),
    .o_func_rst_pf_num      (o_func_rst_pf_num),
    .o_func_rst_vf_num      (o_func_rst_vf_num),
    .i_func_rst_ack         (i_func_rst_ack),
    .o_vf_fifo_full         (o_vf_fifo_full),
    .o_vf_drop              (o_vf_drop)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observer: request targets, request lengths, completions, drops, pulse widths.
  logic [14:0] req_q [$];
  int          len_q [$];
  logic [13:0] comp_q[$];
  int          pf_done_cnt = 0;
  logic [7:0]  last_pf_done = '0;
  int          drop_cnt = 0;
  int          wide_cnt = 0;
  int          run = 0;
  logic        prev_req = 1'b0;
  logic        prev_pf  = 1'b0;
  logic        prev_vf  = 1'b0;

  always @(negedge clk) begin
    if (o_func_rst_req) begin
      if (!prev_req) req_q.push_back({o_func_rst_vf, o_func_rst_pf_num, o_func_rst_vf_num});
      run++;
    end else if (run != 0) begin
      len_q.push_back(run);
      run = 0;
    end
    prev_req = o_func_rst_req;
    if (o_flr_pf_done != 8'h00) begin
      pf_done_cnt++;
      last_pf_done = o_flr_pf_done;
      if (prev_pf) wide_cnt++;
    end
    prev_pf = |o_flr_pf_done;
    if (o_flr_completed_vf) begin
      comp_q.push_back({o_flr_completed_pf_num, o_flr_completed_vf_num});
      if (prev_vf) wide_cnt++;
    end
    prev_vf = o_flr_completed_vf;
    if (o_vf_drop) drop_cnt++;
  end

  task automatic clear_obs();
    req_q.delete();
    len_q.delete();
    comp_q.delete();
    pf_done_cnt = 0;
    drop_cnt    = 0;
  endtask

  task automatic strobe(input logic [2:0] pf, input logic [10:0] vf);
    i_flr_rcvd_vf     = 1'b1;
    i_flr_rcvd_pf_num = pf;
    i_flr_rcvd_vf_num = vf;
    tick();
    i_flr_rcvd_vf     = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 100 && !o_func_rst_req; n++) tick();
    chk(tag, 64'(o_func_rst_req), 64'd1);
  endtask

  function automatic logic [40:0] all_outs();
    return {o_flr_pf_done, o_flr_completed_vf, o_flr_completed_pf_num, o_flr_completed_vf_num,
            o_func_rst_req, o_func_rst_vf, o_func_rst_pf_num, o_func_rst_vf_num,
            o_vf_fifo_full, o_vf_drop};
  endfunction

  initial begin
    rst_n = 1'b0;
    i_flr_pf_active = '0;
    i_flr_rcvd_vf = 1'b0;
    i_flr_rcvd_pf_num = '0;
    i_flr_rcvd_vf_num = '0;
    i_func_rst_ack = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // PF3 level, latency 2, ack 5 cycles into WAIT_ACK, level dropped mid-service
    clear_obs();
    i_flr_pf_active = 8'h08;
    tick();
    tick();
    chk("pf3_req_edge1", 64'(o_func_rst_req), 64'd0);
    tick();
    chk("pf3_req_edge2", 64'(o_func_rst_req), 64'd1);
    chk("pf3_target", 64'({o_func_rst_vf, o_func_rst_pf_num, o_func_rst_vf_num}), 64'({1'b0, 3'd3, 11'd0}));
    i_flr_pf_active = 8'h00;
    repeat (H + 4) tick();
    chk("pf3_req_before_ack", 64'(o_func_rst_req), 64'd1);
    i_func_rst_ack = 1'b1;
    tick();
    i_func_rst_ack = 1'b0;
    chk("pf3_req_low", 64'(o_func_rst_req), 64'd0);
    chk("pf3_done", 64'(o_flr_pf_done), 64'h08);
    chk("pf3_no_vf_cmp", 64'(o_flr_completed_vf), 64'd0);
    tick();
    chk("pf3_done_1cyc", 64'(o_flr_pf_done), 64'h00);
    chk("pf3_len", 64'(len_q.size() > 0 ? len_q[0] : 0), 64'd21);
    repeat (30) tick();
    chk("pf3_single_service", 64'(req_q.size()), 64'd1);

    // Two back-to-back VF strobes, ack held high from the start
    clear_obs();
    i_func_rst_ack = 1'b1;
    i_flr_rcvd_vf = 1'b1; i_flr_rcvd_pf_num = 3'd0; i_flr_rcvd_vf_num = 11'd7;
    tick();
    i_flr_rcvd_pf_num = 3'd1; i_flr_rcvd_vf_num = 11'd2;
    tick();
    i_flr_rcvd_vf = 1'b0;
    chk("vf_req_edge1", 64'(o_func_rst_req), 64'd0);
    tick();
    chk("vf_req_edge2", 64'(o_func_rst_req), 64'd1);
    chk("vf_target0", 64'({o_func_rst_vf, o_func_rst_pf_num, o_func_rst_vf_num}), 64'({1'b1, 3'd0, 11'd7}));
    for (int n = 0; n < 200 && comp_q.size() < 2; n++) tick();
    chk("vf_two_done", 64'(comp_q.size()), 64'd2);
    i_func_rst_ack = 1'b0;
    tick();
    chk("vf_comp0", 64'(comp_q[0]), 64'({3'd0, 11'd7}));
    chk("vf_comp1", 64'(comp_q[1]), 64'({3'd1, 11'd2}));
    chk("vf_target1", 64'(req_q.size() > 1 ? req_q[1] : 15'd0), 64'({1'b1, 3'd1, 11'd2}));
    chk("ack_in_assert_len0", 64'(len_q.size() > 0 ? len_q[0] : 0), 64'd17);
    chk("ack_in_assert_len1", 64'(len_q.size() > 1 ? len_q[1] : 0), 64'd17);

    // Queue overflow while PF5 holds the responder busy
    clear_obs();
    repeat (5) tick();
    i_flr_pf_active = 8'h20;
    wait_req("pf5_req");
    for (int i = 1; i <= 5; i++) strobe(3'd2, 11'(i));
    chk("ovf_drop", 64'(o_vf_drop), 64'd1);
    chk("ovf_full", 64'(o_vf_fifo_full), 64'd1);
    tick();
    chk("ovf_drop_1cyc", 64'(o_vf_drop), 64'd0);
    i_func_rst_ack = 1'b1;
    for (int n = 0; n < 400 && !(pf_done_cnt >= 1 && comp_q.size() >= 4); n++) tick();
    repeat (30) tick();
    i_func_rst_ack = 1'b0;
    i_flr_pf_active = 8'h00;
    chk("ovf_vf_cmp_cnt", 64'(comp_q.size()), 64'd4);
    chk("ovf_first", 64'(comp_q.size() > 0 ? comp_q[0] : 14'd0), 64'({3'd2, 11'd1}));
    chk("ovf_last", 64'(comp_q.size() > 3 ? comp_q[3] : 14'd0), 64'({3'd2, 11'd4}));
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_pf5_done", 64'(last_pf_done), 64'h20);
    chk("ovf_full_clr", 64'(o_vf_fifo_full), 64'd0);

    // PF2 raised while VF (0,9) is queued behind an active VF
    clear_obs();
    repeat (3) tick();
    strobe(3'd0, 11'd11);
    wait_req("prio_first_req");
    strobe(3'd0, 11'd9);
    i_flr_pf_active = 8'h04;
    repeat (2) tick();
    i_func_rst_ack = 1'b1;
    for (int n = 0; n < 300 && !(pf_done_cnt >= 1 && comp_q.size() >= 2); n++) tick();
    repeat (5) tick();
    i_func_rst_ack = 1'b0;
    i_flr_pf_active = 8'h00;
    chk("prio_req_cnt", 64'(req_q.size()), 64'd3);
    chk("prio_pf2_second", 64'(req_q.size() > 1 ? req_q[1] : 15'd0), 64'({1'b0, 3'd2, 11'd0}));
    chk("prio_vf9_third", 64'(req_q.size() > 2 ? req_q[2] : 15'd0), 64'({1'b1, 3'd0, 11'd9}));
    chk("prio_pf2_done", 64'(last_pf_done), 64'h04);
    chk("tgt_hold_req", 64'(o_func_rst_req), 64'd0);
    chk("tgt_hold", 64'({o_func_rst_vf, o_func_rst_pf_num, o_func_rst_vf_num}), 64'({1'b1, 3'd0, 11'd9}));

    // Reset asserted in WAIT_ACK with another VF queued
    clear_obs();
    repeat (3) tick();
    strobe(3'd3, 11'd100);
    strobe(3'd4, 11'd200);
    wait_req("rst_req");
    repeat (H + 2) tick();
    chk("rst_in_wait", 64'(o_func_rst_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 64'(all_outs()), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    i_func_rst_ack = 1'b1;
    repeat (60) tick();
    i_func_rst_ack = 1'b0;
    chk("rst_no_cmp", 64'(comp_q.size()), 64'd0);
    chk("rst_no_new_req", 64'(req_q.size()), 64'd1);
    chk("rst_req_low", 64'(o_func_rst_req), 64'd0);

    chk("pulse_width", 64'(wide_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
